a0_uart_logger: RTL and testbench

Downstream consumer of the CPU's `a0_o` result register. Samples `a0` every cycle, pushes each new value (different from the last captured one) into a small FIFO, and serialises queued words over a UART 8N1 transmit line, 4 bytes per word, little-endian. Lets the team observe program results (e.g. F1 light sequence, PDF counts) on a host terminal without a waveform viewer.

---
 rtl/a0_uart_logger.sv | 156 +++++++++++++++
 tb/tb_a0_uart_logger.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/a0_uart_logger.sv
// Captures each new value of the CPU a0 register into a small FIFO and
// streams queued words out as four little-endian UART 8N1 bytes.
module a0_uart_logger #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DATA_WIDTH-1:0]         a0_i,
    input  logic                          en_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [1:0]                    state_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [BAUD_W-1:0]     baud_cnt, baud_n;
    logic [2:0]            bit_idx, bit_n;
    logic [1:0]            byte_idx, byte_n;
    logic [DATA_WIDTH-1:0] word, word_n;
    logic                  tx_n;
    logic                  baud_done;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] prev;
    logic                  capture, fifo_full, pop, push, drop;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push then.
    assign capture   = en_i && (a0_i != prev);
    assign fifo_full = (count == FULL_CNT);
    assign pop       = (state == S_IDLE) && (count != '0);
    assign push      = capture && (!fifo_full || pop);
    assign drop      = capture && fifo_full && !pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            prev       <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (capture) prev <= a0_i;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (drop) overflow_o <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) mem[wr_ptr] <= a0_i;
    end

    // Transmit FSM: state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            word     <= '0;
            tx_o     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            word     <= word_n;
            tx_o     <= tx_n;
        end
    end

    assign baud_done = (baud_cnt == BAUD_LAST);

    // Transmit FSM: next state; the baud counter restarts on every bit boundary.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt + 1'b1;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        word_n  = word;
        case (state)
            S_IDLE: begin
                baud_n = '0;
                if (count != '0) begin
                    state_n = S_START;
                    word_n  = mem[rd_ptr];
                    byte_n  = '0;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_n = S_DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) state_n = S_STOP;
                    else bit_n = bit_idx + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (byte_idx != 2'd3) begin
                        state_n = S_START;
                        byte_n  = byte_idx + 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Transmit FSM: outputs. The line level is derived from the next state so tx_o can be registered.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = word_n[{byte_n, bit_n}];
            default: tx_n = 1'b1;
        endcase
        busy_o       = (state != S_IDLE) || (count != '0);
        fifo_count_o = count;
        state_o      = state;
    end

endmodule

// File: tb/tb_a0_uart_logger.sv
// Directed bench for a0_uart_logger: a UART receiver model decodes tx and
// compares each received word against the expected-word queue.
module tb_a0_uart_logger;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] a0  = '0;
    logic        tx_o, busy_o, overflow_o;
    logic [3:0]  fifo_count_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    a0_uart_logger #(
        .DATA_WIDTH  (32),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .a0_i        (a0),
        .en_i        (en),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o),
        .fifo_count_o(fifo_count_o),
        .state_o     (state_o)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver helpers: inputs change and outputs are checked 1 time unit after a rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < limit) begin
            cyc(1);
            n++;
        end
        chk("wait_idle", 64'(busy_o), 64'd0);
    endtask

    // Receiver model: sample each bit in its first cycle, counting from the start-bit fall.
    int          rx_tick   = 0;
    logic        rx_active = 1'b0;
    logic        rx_last   = 1'b0;
    logic [7:0]  rx_byte   = '0;
    logic [31:0] rx_word   = '0;
    int          rx_nbytes = 0;
    int          rx_words  = 0;
    logic [31:0] rx_exp;

    always @(negedge clk) begin
        if (rst) begin
            rx_active = 1'b0;
            rx_nbytes = 0;
            rx_last   = 1'b0;
            rx_word   = '0;
        end else if (!rx_active) begin
            if (rx_last && !tx_o) begin
                rx_active = 1'b1;
                rx_tick   = 0;
            end
            rx_last = tx_o;
        end else begin
            rx_tick++;
            if ((rx_tick % CPB) == 0 && rx_tick <= 8 * CPB)
                rx_byte[rx_tick / CPB - 1] = tx_o;
            if (rx_tick == 9 * CPB) begin
                checks++;
                assert (tx_o === 1'b1) else begin
                    errors++;
                    $error("FAIL rx_stop observed=%b expected=1", tx_o);
                end
                rx_word[8 * rx_nbytes +: 8] = rx_byte;
                rx_nbytes++;
                if (rx_nbytes == 4) begin
                    rx_nbytes = 0;
                    rx_words++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $error("FAIL rx_unexpected observed=%08h expected=none", rx_word);
                    end else begin
                        rx_exp = exp_q.pop_front();
                        assert (rx_word === rx_exp) else begin
                            errors++;
                            $error("FAIL rx_word observed=%08h expected=%08h", rx_word, rx_exp);
                        end
                    end
                end
                rx_active = 1'b0;
                rx_last   = tx_o;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int maxc;
        int n;

        // Reset state
        rst = 1'b1;
        cyc(3);
        chk("rst_tx", 64'(tx_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_count", 64'(fifo_count_o), 64'd0);
        chk("rst_state", 64'(state_o), 64'd0);
        rst = 1'b0;
        en  = 1'b1;
        cyc(2);
        chk("zero_not_pushed", 64'(fifo_count_o), 64'd0);

        // Single word 0xA5: count up after the sampling edge, tx low one edge later, 160-cycle frame
        a0 = 32'h0000_00A5;
        exp_q.push_back(32'h0000_00A5);
        cyc(1);
        chk("t1_count1", 64'(fifo_count_o), 64'd1);
        chk("t1_tx_idle", 64'(tx_o), 64'd1);
        chk("t1_busy", 64'(busy_o), 64'd1);
        cyc(1);
        chk("t1_tx_start", 64'(tx_o), 64'd0);
        chk("t1_count0", 64'(fifo_count_o), 64'd0);
        cyc(159);
        chk("t1_busy_end", 64'(busy_o), 64'd1);
        cyc(1);
        chk("t1_idle_busy", 64'(busy_o), 64'd0);
        chk("t1_idle_tx", 64'(tx_o), 64'd1);

        // Held value is sent exactly once
        a0 = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        maxc = 0;
        for (int i = 0; i < 500; i++) begin
            cyc(1);
            if (int'(fifo_count_o) > maxc) maxc = int'(fifo_count_o);
        end
        chk("t2_max_count", 64'(maxc), 64'd1);
        chk("t2_busy", 64'(busy_o), 64'd0);

        // Burst 1..12: one in flight, eight queued, three dropped
        for (int i = 1; i <= 12; i++) begin
            a0 = 32'(i);
            if (i <= 9) exp_q.push_back(32'(i));
            cyc(1);
            if (i == 9) begin
                chk("t3_full_count", 64'(fifo_count_o), 64'(DEPTH));
                chk("t3_no_ovf_yet", 64'(overflow_o), 64'd0);
            end
        end
        chk("t3_ovf", 64'(overflow_o), 64'd1);
        chk("t3_count", 64'(fifo_count_o), 64'(DEPTH));
        wait_idle(2000);
        chk("t3_ovf_sticky", 64'(overflow_o), 64'd1);

        // Reset during DATA of byte 2 abandons the frame; same a0 re-captured afterwards
        a0 = 32'hCAFE_0042;
        cyc(2);
        cyc(100);
        chk("t5_in_data", 64'(state_o), 64'd2);
        rst = 1'b1;
        cyc(1);
        chk("t5_tx", 64'(tx_o), 64'd1);
        chk("t5_count", 64'(fifo_count_o), 64'd0);
        chk("t5_busy", 64'(busy_o), 64'd0);
        chk("t5_ovf", 64'(overflow_o), 64'd0);
        chk("t5_state", 64'(state_o), 64'd0);
        rst = 1'b0;
        exp_q.push_back(32'hCAFE_0042);
        cyc(1);
        chk("t5_recapture", 64'(fifo_count_o), 64'd1);
        wait_idle(400);

        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 9; i++) begin
            a0 = 32'h101 + 32'(i);
            exp_q.push_back(32'h101 + 32'(i));
            cyc(1);
        end
        chk("t6_full", 64'(fifo_count_o), 64'(DEPTH));
        n = 0;
        while (state_o !== 2'd0 && n < 400) begin
            cyc(1);
            n++;
        end
        chk("t6_idle_seen", 64'(state_o), 64'd0);
        chk("t6_idle_full", 64'(fifo_count_o), 64'(DEPTH));
        a0 = 32'h200;
        exp_q.push_back(32'h200);
        cyc(1);
        chk("t6_count_kept", 64'(fifo_count_o), 64'(DEPTH));
        chk("t6_no_ovf", 64'(overflow_o), 64'd0);
        chk("t6_start", 64'(state_o), 64'd1);
        wait_idle(2500);

        // Capture disabled: no push while a0 changes
        en = 1'b0;
        a0 = 32'd5;
        cyc(1);
        a0 = 32'd7;
        cyc(2);
        chk("t4_busy", 64'(busy_o), 64'd0);
        chk("t4_count", 64'(fifo_count_o), 64'd0);
        en = 1'b1;
        exp_q.push_back(32'd7);
        cyc(1);
        chk("t4_push", 64'(fifo_count_o), 64'd1);
        wait_idle(400);
        cyc(4);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("rx_words", 64'(rx_words), 64'd23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
